// File: rtl/card_shoe.sv
// 52-card shoe dealt without replacement: LFSR-picked start index, linear probe to the next undealt card.
// Define CARD_SHOE_AUTO_RESHUFFLE_EN to refill the shoe automatically when a request arrives while empty.
module card_shoe #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req,
  input  logic       i_shuffle,
  output logic [5:0] o_card,
  output logic       o_valid,
  output logic       o_busy,
  output logic [5:0] o_cards_left,
  output logic       o_empty
);

  typedef enum logic {IDLE, PROBE} state_t;

  state_t      state;
  logic [51:0] used;
  logic [5:0]  idx;
  logic [15:0] lfsr;

  logic [15:0] lfsr_next;
  logic [5:0]  start_idx;
  logic [5:0]  idx_next;
  logic [5:0]  card_enc;

  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    start_idx = (lfsr[5:0] >= 6'd52) ? (lfsr[5:0] - 6'd52) : lfsr[5:0];
    idx_next  = (idx == 6'd51) ? 6'd0 : (idx + 6'd1);
    // rank = idx - 13*suit + 1, computed mod 16 on the low nibble (result always 1..13)
    if (idx < 6'd13)      card_enc = {2'd0, idx[3:0] + 4'd1};
    else if (idx < 6'd26) card_enc = {2'd1, idx[3:0] - 4'd12};
    else if (idx < 6'd39) card_enc = {2'd2, idx[3:0] - 4'd9};
    else                  card_enc = {2'd3, idx[3:0] - 4'd6};
  end

  assign o_empty = (o_cards_left == 6'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      used         <= '0;
      idx          <= '0;
      lfsr         <= SEED;
      o_card       <= '0;
      o_valid      <= 1'b0;
      o_busy       <= 1'b0;
      o_cards_left <= 6'd52;
    end else begin
      lfsr    <= lfsr_next;
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_shuffle) begin
            used         <= '0;
            o_cards_left <= 6'd52;
          end else if (i_req) begin
            if (!o_empty) begin
              idx    <= start_idx;
              state  <= PROBE;
              o_busy <= 1'b1;
            end
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
            else begin
              used         <= '0;
              o_cards_left <= 6'd52;
              idx          <= start_idx;
              state        <= PROBE;
              o_busy       <= 1'b1;
            end
`endif
          end
        end
        PROBE: begin
          if (i_shuffle) begin
            used         <= '0;
            o_cards_left <= 6'd52;
            o_busy       <= 1'b0;
            state        <= IDLE;
          end else if (used[idx]) begin
            idx <= idx_next;
          end else begin
            used[idx]    <= 1'b1;
            o_card       <= card_enc;
            o_valid      <= 1'b1;
            o_cards_left <= o_cards_left - 6'd1;
            o_busy       <= 1'b0;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: first draw, full shoe, empty request, shuffle/abort, ignored requests, async reset.
module tb_card_shoe;

  logic       clk;
  logic       reset;
  logic       req;
  logic       shuffle;
  logic [5:0] card;
  logic       valid;
  logic       busy;
  logic [5:0] cards_left;
  logic       empty;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [51:0] seen;
  int          exp_left;

  card_shoe #(.SEED(16'hACE1)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .i_shuffle    (shuffle),
    .o_card       (card),
    .o_valid      (valid),
    .o_busy       (busy),
    .o_cards_left (cards_left),
    .o_empty      (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One spaced request; checks latency, legality, uniqueness and the remaining count.
  task automatic deal_check(input string tag);
    logic got;
    int   lat;
    int   ci;
    logic [3:0] rank;
    got = 1'b0;
    lat = 0;
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (!got) begin
        @(posedge clk); #1;
        if (valid) begin
          got = 1'b1;
          lat = c;
        end
      end
    end
    check({tag, "_valid"}, got, 1);
    if (got) begin
      exp_left--;
      rank = card[3:0];
      check({tag, "_latency_le52"}, (lat >= 1 && lat <= 52), 1);
      check({tag, "_rank_legal"}, (rank >= 4'd1 && rank <= 4'd13), 1);
      if (rank >= 4'd1 && rank <= 4'd13) begin
        ci = int'(card[5:4]) * 13 + int'(rank) - 1;
        check({tag, "_distinct"}, seen[ci], 0);
        seen[ci] = 1'b1;
      end
      check({tag, "_cards_left"}, cards_left, exp_left);
    end
  endtask

  initial begin
    int   nvalid;
    logic toggle;
    logic saw_busy;
    logic saw_valid;

    reset = 1'b1; req = 1'b0; shuffle = 1'b0;
    seen = '0;
    #2;
    check("rst_card", card, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_left", cards_left, 52);
    check("rst_empty", empty, 0);

    // First draw straight out of reset: lfsr = ACE1 -> idx 33 -> suit 2 rank 8
    @(negedge clk); reset = 1'b0; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    check("first_busy", busy, 1);
    check("first_valid_early", valid, 0);
    @(posedge clk); #1;
    check("first_valid", valid, 1);
    check("first_card", card, 6'h28);
    check("first_left", cards_left, 51);
    check("first_busy_fall", busy, 0);
    @(posedge clk); #1;
    check("first_valid_pulse", valid, 0);
    seen[33] = 1'b1;
    exp_left = 51;

    repeat (51) deal_check("full");
    check("full_left", cards_left, 0);
    check("full_empty", empty, 1);
    check("full_all_seen", (seen == {52{1'b1}}), 1);

`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
    seen = '0;
    exp_left = 52;
    deal_check("auto");
    check("auto_left", cards_left, 51);
`else
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    saw_busy = busy;
    saw_valid = valid;
    repeat (60) begin
      @(posedge clk); #1;
      saw_busy  = saw_busy | busy;
      saw_valid = saw_valid | valid;
    end
    check("empty_no_busy", saw_busy, 0);
    check("empty_no_valid", saw_valid, 0);
    check("empty_stays", empty, 1);
`endif

    @(negedge clk); shuffle = 1'b1;
    @(posedge clk); #1; shuffle = 1'b0;
    check("shuffle_left", cards_left, 52);
    check("shuffle_empty", empty, 0);
    seen = '0;
    exp_left = 52;

    repeat (51) deal_check("deal51");

    // Abort a probe with shuffle while busy
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    check("abort_busy", busy, 1);
    @(negedge clk); shuffle = 1'b1;
    @(posedge clk); #1; shuffle = 1'b0;
    check("abort_valid", valid, 0);
    check("abort_busy_low", busy, 0);
    check("abort_left", cards_left, 52);
    saw_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      saw_valid = saw_valid | valid;
    end
    check("abort_no_late_valid", saw_valid, 0);

    // Requests toggled while busy must not start extra deals
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    nvalid = 0;
    toggle = 1'b0;
    repeat (60) begin
      @(negedge clk);
      toggle = ~toggle;
      req = busy & toggle;
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    req = 1'b0;
    check("ignored_one_valid", nvalid, 1);
    check("ignored_left", cards_left, 51);

    // Request together with shuffle in IDLE: shuffle wins, no deal
    @(negedge clk); req = 1'b1; shuffle = 1'b1;
    @(posedge clk); #1; req = 1'b0; shuffle = 1'b0;
    check("reqshuf_busy", busy, 0);
    check("reqshuf_left", cards_left, 52);
    saw_busy = 1'b0;
    saw_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      saw_busy  = saw_busy | busy;
      saw_valid = saw_valid | valid;
    end
    check("reqshuf_no_busy", saw_busy, 0);
    check("reqshuf_no_valid", saw_valid, 0);

    seen = '0;
    exp_left = 52;
    deal_check("pre_reset");

    // Asynchronous reset in the middle of a probe
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    check("midrst_busy", busy, 1);
    #2; reset = 1'b1;
    #1;
    check("midrst_card", card, 0);
    check("midrst_valid", valid, 0);
    check("midrst_busy_low", busy, 0);
    check("midrst_left", cards_left, 52);
    check("midrst_empty", empty, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
